w_loader: RTL

//  Upstream weight-fill stage for the 16-bank weight memories read by the layer engine.

---
 rtl/w_loader.sv | 90 +++++++++
 1 files changed

// File: rtl/w_loader.sv
// Weight-fill stage: streams bytes into 16 interleaved weight banks and pulses
// load_done once the whole image has been committed.
module w_loader #(
  parameter int unsigned NBANK = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                         clk,
  input  logic                         xrst,
  input  logic                         load_start,
  input  logic                         abort,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DW-1:0]                s_data,
  output logic [NBANK-1:0]             w_we,
  output logic [AW-1:0]                w_waddr,
  output logic [DW-1:0]                w_wdata,
  output logic                         busy,
  output logic                         load_done,
  output logic [$clog2(NBANK)+AW:0]    bytes_loaded
);

  localparam int unsigned BW    = $clog2(NBANK);
  localparam int unsigned CW    = BW + AW + 1;
  localparam int unsigned TOTAL = NBANK * (2 ** AW);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          accept;
  logic          last;

  // Abort masks ready in the same cycle so the offered byte is never taken.
  always_comb begin
    s_ready = 1'b0;
    accept  = 1'b0;
    s_ready = (state == LOAD) && !abort;
    accept  = s_ready && s_valid;
  end

  assign last         = (count == CW'(TOTAL - 1));
  assign busy         = (state != IDLE);
  assign bytes_loaded = count;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state     <= IDLE;
      count     <= '0;
      w_we      <= '0;
      w_waddr   <= '0;
      w_wdata   <= '0;
      load_done <= 1'b0;
    end else begin
      w_we      <= '0;
      load_done <= 1'b0;

      // Byte k lands in bank k%NBANK at address k/NBANK, one cycle after accept.
      if (accept) begin
        w_we    <= NBANK'(1) << count[BW-1:0];
        w_waddr <= count[BW +: AW];
        w_wdata <= s_data;
        count   <= count + CW'(1);
      end

      case (state)
        IDLE: begin
          if (load_start && !abort) begin
            state <= LOAD;
            count <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            count <= '0;
          end else if (accept && last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state     <= IDLE;
          load_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
